// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared serial line definitions for the receive and transmit sides
//
// Purpose : common state encoding and line idle level for the serial blocks.
// Macro   : SERIAL_RX_PARITY_EN adds the PARITY state to the enum.
package serial_pkg;

  // An undriven or idle serial line sits high.
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef SERIAL_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } serial_state_t;

endpackage

// File: rtl/serial_sync2.sv
// rtl/serial_sync2.sv - two-flop synchronizer for a single asynchronous input
//
// Purpose : bring an asynchronous level into the clk domain.
// Ports   : clk   - sampling clock
//           rst   - asynchronous active-high reset, both flops load RESET_VAL
//           d     - asynchronous input
//           q     - synchronized output (two clk cycles of latency)
module serial_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - oversampled serial receiver with a one-byte holding register
//
// Purpose : receive start + DATA_BITS (LSB first) [+ even parity] + stop frames,
//           sampling each bit at its middle, and hand bytes over with valid/ready.
// Macro   : SERIAL_RX_PARITY_EN adds an even-parity bit and the parity_err output.
// Ports   : clk        - rising-edge clock
//           rst        - asynchronous active-high reset
//           rx_in      - asynchronous serial line, idle high
//           rx_data    - received payload, valid while rx_valid=1
//           rx_valid   - holding register has an unread byte
//           rx_ready   - consumer takes the byte when rx_valid & rx_ready
//           frame_err  - one-cycle pulse, stop bit sampled low
//           overrun    - sticky, a good frame was dropped because the holder was full
//           parity_err - (macro only) one-cycle pulse, parity mismatch
module serial_rx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
`ifdef SERIAL_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 overrun
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  serial_state_t        state;
  logic [TW-1:0]        timer;
  logic [CW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_s;
  logic                 rx_prev;
  logic                 stop_hi;
  logic                 good_frame;

  serial_sync2 #(.RESET_VAL(IDLE_LEVEL)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

  assign stop_hi = (rx_s == IDLE_LEVEL);

`ifdef SERIAL_RX_PARITY_EN
  logic par_bit;
  logic par_bad;
  // Even parity: data bits plus parity bit carry an even number of ones.
  assign par_bad    = (par_bit != ^shreg);
  assign good_frame = stop_hi && !par_bad;
`else
  assign good_frame = stop_hi;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      timer     <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_prev   <= IDLE_LEVEL;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      rx_prev <= rx_s;

      // Consumer handshake; a load in STOP below overrides this on the same cycle.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          timer   <= '0;
          bit_cnt <= '0;
          if (rx_prev == IDLE_LEVEL && rx_s != IDLE_LEVEL) state <= ST_START;
        end

        ST_START: begin
          if (timer == HALF_M1) begin
            timer <= '0;
            // Line back high by mid-start means a glitch, not a frame.
            state <= stop_hi ? ST_IDLE : ST_DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_DATA: begin
          if (timer == FULL_M1) begin
            timer   <= '0;
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
`ifdef SERIAL_RX_PARITY_EN
              state   <= ST_PARITY;
`else
              state   <= ST_STOP;
`endif
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

`ifdef SERIAL_RX_PARITY_EN
        ST_PARITY: begin
          if (timer == FULL_M1) begin
            timer   <= '0;
            par_bit <= rx_s;
            state   <= ST_STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (timer == FULL_M1) begin
            timer     <= '0;
            state     <= ST_IDLE;
            frame_err <= !stop_hi;
`ifdef SERIAL_RX_PARITY_EN
            parity_err <= par_bad;
`endif
            if (good_frame) begin
              if (!rx_valid || rx_ready) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// tb/tb_serial_rx.sv - self-checking bench for serial_rx
module tb_serial_rx;

  localparam int CPB = 16;
  localparam int DB  = 8;
`ifdef SERIAL_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          rx_in    = 1'b1;
  logic          rx_ready = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          overrun;
  logic          parity_err;

  serial_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
`ifdef SERIAL_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun   (overrun)
  );

`ifndef SERIAL_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Pulse monitor: total high cycles and number of rising edges per error flag.
  int   fe_cycles = 0, fe_rises = 0, pe_cycles = 0, pe_rises = 0;
  logic fe_q = 1'b0, pe_q = 1'b0;
  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cycles++;
    if (frame_err === 1'b1 && fe_q !== 1'b1) fe_rises++;
    fe_q = frame_err;
    if (parity_err === 1'b1) pe_cycles++;
    if (parity_err === 1'b1 && pe_q !== 1'b1) pe_rises++;
    pe_q = parity_err;
  end

  // Reference model of what the consumer should see.
  logic [DB-1:0] m_data  = '0;
  logic          m_valid = 1'b0;
  logic          m_ovr   = 1'b0;
  int            m_fe    = 0;
  int            m_pe    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    wait_cycles(CPB);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop_ok, input logic par_ok);
    logic bad_par, good;
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit((^d) ^ ~par_ok);
    drive_bit(stop_ok);
    rx_in = 1'b1;
    bad_par = PAR_EN && !par_ok;
    good    = stop_ok && !bad_par;
    if (!stop_ok) m_fe++;
    if (bad_par) m_pe++;
    if (good && (rx_ready || !m_valid)) m_data = d;
    if (good && !rx_ready && m_valid) m_ovr = 1'b1;
    m_valid = rx_ready ? 1'b0 : (m_valid || good);
  endtask

  task automatic check_state(input string tag);
    check({tag, ".valid"},     rx_valid,  m_valid);
    check({tag, ".data"},      rx_data,   m_data);
    check({tag, ".overrun"},   overrun,   m_ovr);
    check({tag, ".fe_cycles"}, fe_cycles, m_fe);
    check({tag, ".fe_rises"},  fe_rises,  m_fe);
    check({tag, ".pe_cycles"}, pe_cycles, m_pe);
    check({tag, ".pe_rises"},  pe_rises,  m_pe);
  endtask

  task automatic accept(input string tag);
    rx_ready = 1'b1;
    wait_cycles(1);
    rx_ready = 1'b0;
    m_valid  = 1'b0;
    check({tag, ".accept_valid"}, rx_valid, 1'b0);
  endtask

  initial begin
    logic [DB-1:0] d;
    logic          s_ok, p_ok;

    // Reset values
    wait_cycles(3);
    check("reset.valid", rx_valid, 1'b0);
    check("reset.data", rx_data, '0);
    check("reset.frame_err", frame_err, 1'b0);
    check("reset.overrun", overrun, 1'b0);
    check("reset.parity_err", parity_err, 1'b0);
    rst = 1'b0;
    wait_cycles(CPB);

    // Basic good frame, checked right at the end of the stop bit
    send_frame(8'hA5, 1'b1, 1'b1);
    check("a5.valid_early", rx_valid, 1'b1);
    check("a5.data_early", rx_data, 8'hA5);
    wait_cycles(CPB);
    check_state("a5");
    accept("a5");

    // Short low glitch on an idle line
    rx_in = 1'b0;
    wait_cycles(5);
    rx_in = 1'b1;
    wait_cycles(3 * CPB);
    check_state("glitch");

    // Stop bit low
    send_frame(8'h3C, 1'b0, 1'b1);
    wait_cycles(CPB);
    check_state("framing");

    // Overrun: two frames with nobody reading
    send_frame(8'h11, 1'b1, 1'b1);
    wait_cycles(CPB);
    send_frame(8'h22, 1'b1, 1'b1);
    wait_cycles(CPB);
    check_state("overrun");
    accept("overrun");

    // Reset in the middle of bit 4 of 0xFF
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    wait_cycles(CPB / 2);
    rst = 1'b1;
    wait_cycles(2);
    check("midrst.valid", rx_valid, 1'b0);
    check("midrst.data", rx_data, '0);
    check("midrst.frame_err", frame_err, 1'b0);
    check("midrst.overrun", overrun, 1'b0);
    check("midrst.parity_err", parity_err, 1'b0);
    rx_in = 1'b1;
    rst   = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
    m_ovr   = 1'b0;
    wait_cycles(2 * CPB);
    check_state("midrst.idle");
    send_frame(8'h5A, 1'b1, 1'b1);
    wait_cycles(CPB);
    check_state("after_rst");
    accept("after_rst");

    if (PAR_EN) begin
      send_frame(8'h07, 1'b1, 1'b0);
      wait_cycles(CPB);
      check_state("par_bad");
      send_frame(8'h07, 1'b1, 1'b1);
      wait_cycles(CPB);
      check_state("par_good");
      send_frame(8'h07, 1'b0, 1'b0);
      wait_cycles(CPB);
      check_state("par_both");
      accept("par");
    end

    // Randomized frames
    for (int n = 0; n < 12; n++) begin
      d        = DB'($urandom);
      s_ok     = ($urandom_range(0, 3) != 0);
      p_ok     = ($urandom_range(0, 3) != 0);
      rx_ready = ($urandom_range(0, 2) == 0);
      send_frame(d, s_ok, p_ok);
      wait_cycles(CPB);
      rx_ready = 1'b0;
      check_state($sformatf("rand%0d", n));
      if ($urandom_range(0, 1) == 1) accept($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_rx.md
SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per serial bit; legal range 4..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, payload bits per frame; legal range 5..8.
REQ-003 SHALL have port clk  input  1  single rising-edge clock for all logic.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx_in  input  1  asynchronous serial line; idle high; LSB first.
REQ-006 SHALL have port rx_data  output  DATA_BITS  received payload, valid while rx_valid=1.
REQ-007 SHALL have port rx_valid  output  1  holding register contains an unread byte.
REQ-008 SHALL have port rx_ready  input  1  consumer accepts the byte when rx_valid&rx_ready.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 SHALL have port overrun  output  1  sticky flag: a frame completed while rx_valid=1 and was not accepted.

Function
REQ-011 SHALL pass rx_in through a 2-flop synchronizer before any use; all timing below counts from the synchronized signal.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY (macro-only), STOP.
REQ-013 IDLE: a 1->0 transition on the synchronized line SHALL enter START and clear the bit-timer.
REQ-014 START: at timer = CLKS_PER_BIT/2 - 1 the line SHALL be resampled; if low -> DATA, timer cleared; if high -> IDLE (glitch rejected, no flags).
REQ-015 DATA: each bit SHALL be sampled when timer = CLKS_PER_BIT - 1 (mid-bit), shifted in LSB first; after DATA_BITS samples -> PARITY if enabled, else STOP.
REQ-016 STOP: sample at mid-bit; if high, load shift register into rx_data and set rx_valid the following cycle; if low, pulse frame_err for one cycle, discard the byte, leave rx_valid unchanged.
REQ-017 After STOP the FSM SHALL return to IDLE immediately and be able to detect a new start edge on the next cycle.
REQ-018 rx_valid SHALL clear on the cycle after rx_valid&rx_ready; rx_data SHALL hold until then.
REQ-019 If a good frame completes while rx_valid=1 and rx_ready=0, the old byte SHALL be kept, the new byte dropped, and overrun set; if rx_ready=1 on that same cycle, the new byte SHALL load and overrun SHALL stay clear.
REQ-020 overrun SHALL clear only on reset.
REQ-021 The bit-timer SHALL be ceil(log2(CLKS_PER_BIT)) bits wide and SHALL never wrap mid-bit.

Reset
REQ-022 Reset SHALL force state IDLE, timer 0, bit count 0, synchronizer flops 1, rx_data 0, rx_valid 0, frame_err 0, overrun 0.
REQ-023 Reset asserted mid-frame SHALL abandon the frame with no output pulses; reception resumes on the next falling edge after release.

Configuration
REQ-024 Macro SERIAL_RX_PARITY_EN SHALL, when defined, add the PARITY state, an even-parity bit after the data bits, and an output parity_err (1-bit, one-cycle pulse, reset 0).
REQ-025 With SERIAL_RX_PARITY_EN: parity mismatch SHALL pulse parity_err at the stop-bit sample and discard the byte; a frame with both errors pulses both flags.
REQ-026 Without SERIAL_RX_PARITY_EN: no PARITY state and no parity_err port exist; frames are start + DATA_BITS + stop.

Structure
REQ-027 A shared package serial_pkg SHALL hold the state enum type and the IDLE_LEVEL constant, shared with the transmit side.
REQ-028 The synchronizer SHALL be a separate sub-module, serial_sync2, reused elsewhere in the design.

Verification
REQ-029 CLKS_PER_BIT=16, send 0xA5 at 16 clk/bit -> rx_data=0xA5, rx_valid=1 within 20 cycles after mid-stop, frame_err=0.
REQ-030 Low glitch of 5 cycles on idle line -> FSM returns to IDLE, rx_valid, frame_err, overrun all stay 0.
REQ-031 Send 0x3C with stop bit low -> single-cycle frame_err pulse, rx_valid stays 0.
REQ-032 Send 0x11 then 0x22 with rx_ready=0 -> rx_data=0x11, overrun=1; then assert rx_ready -> rx_valid drops next cycle.
REQ-033 Assert rst during bit 4 of 0xFF -> all outputs 0; then send 0x5A -> rx_data=0x5A received correctly.
REQ-034 With SERIAL_RX_PARITY_EN, send 0x07 with parity bit 0 -> parity_err pulse, no rx_valid; with correct parity bit 1 -> rx_data=0x07.
